axi_interface: RTL and testbench

// - Instruction-fetch bridge between the pipeline fetch stage and an AXI4 read-only slave (AR + R channels).
// - Takes the current pc, issues one single-beat 64-bit read, extracts the 32-bit instruction word and

---
 rtl/axi_interface.sv | 156 +++++++++++++++
 tb/tb_axi_interface.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axi_interface.sv
`default_nettype none
// ============================================================================
// Module   : axi_interface
// Purpose  : Instruction-fetch bridge. Launches one single-beat 64-bit AXI4
//            read (AR + R channels) for the current pc. It then returns the
//            selected 32-bit half of RDATA on instr, with a one-cycle
//            instr_valid pulse. Only one transaction is ever outstanding.
// Ports    : clk, rstn (synchronous, active-high despite the name)
//            pc -> instr / instr_valid          fetch-stage side
//            AR* outputs, ARREADY input          read-address channel
//            RID/RDATA/RRESP/RLAST/RVALID, RREADY read-data channel
// Options  : AXI_RESP_CHECK_EN - when defined, a non-OKAY RRESP delivers
//            NOP_INSTR instead of the data word.
// Revision : 1.0  initial release
// ============================================================================
module axi_interface #(
    parameter logic [3:0]  AXI_ID    = 4'h0,
    parameter logic [2:0]  AR_PROT   = 3'b100,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [3:0]  ARID,
    output logic [63:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARLOCK,
    output logic [3:0]  ARCACHE,
    output logic [2:0]  ARPORT,
    output logic [3:0]  ARQOS,
    output logic [3:0]  ARREGION,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [3:0]  RID,
    input  logic [63:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sel;
    logic        w_sel_nxt;
    logic        r_arvalid;
    logic        w_arvalid_nxt;
    logic [63:0] r_araddr;
    logic [63:0] w_araddr_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic        r_instr_valid;
    logic        w_instr_valid_nxt;
    logic [31:0] w_word;

    // Half of the 64-bit beat chosen by pc[2] captured at launch.
    assign w_word = r_sel ? RDATA[63:32] : RDATA[31:0];

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state       <= S_IDLE;
            r_sel         <= 1'b0;
            r_arvalid     <= 1'b0;
            r_araddr      <= 64'd0;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_araddr      <= w_araddr_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_arvalid_nxt     = r_arvalid;
        w_araddr_nxt      = r_araddr;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                // pc is only sampled here; later changes cannot disturb
                // the request in flight.
                w_araddr_nxt  = {pc[63:3], 3'b000};
                w_sel_nxt     = pc[2];
                w_arvalid_nxt = 1'b1;
                w_state_nxt   = S_ADDR;
            end
            S_ADDR: begin
                if (ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (RVALID) begin
`ifdef AXI_RESP_CHECK_EN
                    w_instr_nxt = (RRESP != 2'b00) ? NOP_INSTR : w_word;
`else
                    w_instr_nxt = w_word;
`endif
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign ARVALID     = r_arvalid;
    assign ARADDR      = r_araddr;
    assign RREADY      = (r_state == S_DATA);

    assign ARID     = AXI_ID;
    assign ARLEN    = 8'd0;
    assign ARSIZE   = 3'b011;
    assign ARBURST  = 2'b01;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'd0;
    assign ARPORT   = AR_PROT;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;

    // Inputs that a single-beat, in-order fetch has no use for.
`ifdef AXI_RESP_CHECK_EN
    logic w_unused;
    assign w_unused = &{1'b0, RID, RLAST, pc[1:0]};
`else
    logic w_unused;
    assign w_unused = &{1'b0, RID, RLAST, pc[1:0], RRESP, NOP_INSTR};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_interface
// Purpose  : Self-checking bench for axi_interface. A transaction-level model
//            of the fetch bridge predicts every output each cycle. Directed
//            scenarios pin the model with literal values, then a randomized
//            slave / pc / reset phase follows.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_interface;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARLOCK;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPORT;
    logic [3:0]  ARQOS;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_interface dut (
        .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPORT(ARPORT),
        .ARQOS(ARQOS), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    // ---------------- transaction-level reference model ----------------
    // busy      : a fetch has been launched and not yet retired
    // ar_wait   : address phase outstanding
    // r_wait    : address accepted, waiting for the data beat
    // pulse     : the instruction was delivered on the last edge
    logic        m_busy = 0, m_ar_wait = 0, m_r_wait = 0, m_pulse = 0;
    logic [63:0] m_addr = 0;
    logic        m_upper = 0;
    logic [31:0] m_instr = 0;
    int          m_pulses = 0;
    int          d_pulses = 0;

    always @(posedge clk) begin
        if (rstn) begin
            m_busy = 0; m_ar_wait = 0; m_r_wait = 0; m_pulse = 0;
            m_addr = 0; m_upper = 0; m_instr = 0;
        end else if (!m_busy) begin
            m_addr    = pc & ~64'h7;
            m_upper   = pc[2];
            m_busy    = 1;
            m_ar_wait = 1;
        end else if (m_ar_wait) begin
            if (ARREADY) begin
                m_ar_wait = 0;
                m_r_wait  = 1;
            end
        end else if (m_r_wait) begin
            if (RVALID) begin
                m_r_wait = 0;
                m_pulse  = 1;
                m_pulses++;
                m_instr  = m_upper ? RDATA[63:32] : RDATA[31:0];
`ifdef AXI_RESP_CHECK_EN
                if (RRESP != 2'b00) m_instr = 32'h00000013;
`endif
            end
        end else begin
            m_pulse = 0;
            m_busy  = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic step();
        @(negedge clk);
        if (instr_valid === 1'b1) d_pulses++;
        chk("ARVALID", {63'd0, ARVALID}, {63'd0, m_ar_wait});
        chk("ARADDR",  ARADDR, m_addr);
        chk("RREADY",  {63'd0, RREADY}, {63'd0, m_r_wait});
        chk("instr",   {32'd0, instr}, {32'd0, m_instr});
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_pulse});
        chk("ar_const", {31'd0, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPORT, ARQOS, ARREGION},
                        {31'd0, 4'h0, 8'h00, 3'b011, 2'b01, 1'b0, 4'h0, 3'b100, 4'h0, 4'h0});
    endtask

    localparam logic [63:0] C_RD = 64'h00000013_00100093;

    initial begin
        rstn = 1; pc = 64'h80000000; ARREADY = 1; RVALID = 1; RDATA = C_RD;
        RRESP = 2'b00; RID = 4'h0; RLAST = 1'b1;
        repeat (2) step();
        chk("rst_ARVALID", {63'd0, ARVALID}, 64'd0);
        chk("rst_ARADDR", ARADDR, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_RREADY", {63'd0, RREADY}, 64'd0);

        // Aligned lower word, zero-wait slave.
        rstn = 0;
        step(); chk("lit_arv", {63'd0, ARVALID}, 64'd1); chk("lit_addr0", ARADDR, 64'h80000000);
        step(); chk("lit_rready", {63'd0, RREADY}, 64'd1);
        step(); chk("lit_pulse0", {63'd0, instr_valid}, 64'd1); chk("lit_instr0", {32'd0, instr}, 64'h00100093);
        pc = 64'h80000004;
        // Upper word; pulse exactly 4 cycles later.
        step(); chk("lit_pulse_len", {63'd0, instr_valid}, 64'd0);
        step(); chk("lit_addr1", ARADDR, 64'h80000000);
        step();
        step(); chk("lit_pulse1", {63'd0, instr_valid}, 64'd1); chk("lit_instr1", {32'd0, instr}, 64'h00000013);
        pc = 64'h80000008;
        step();
        step(); chk("lit_addr2", ARADDR, 64'h80000008);
        ARREADY = 0;
        step();
        step(); chk("lit_instr_held", {32'd0, instr}, 64'h00000013);

        // Backpressure: AR stalled, then R stalled.
        pc = 64'h80000010; RDATA = 64'hCAFEBABE_11223344;
        for (int i = 0; i < 3; i++) step();
        chk("lit_arv_held", {63'd0, ARVALID}, 64'd1); chk("lit_addr_held", ARADDR, 64'h80000008);
        ARREADY = 1; RVALID = 0;
        step(); step(); chk("lit_rready_held", {63'd0, RREADY}, 64'd1);
        RVALID = 1;
        step(); chk("lit_pulse_bp", {63'd0, instr_valid}, 64'd1); chk("lit_instr_bp", {32'd0, instr}, 64'h11223344);

        // Error response.
        pc = 64'h80000014; RRESP = 2'b10;
        repeat (4) step();
        chk("lit_pulse_err", {63'd0, instr_valid}, 64'd1);
`ifdef AXI_RESP_CHECK_EN
        chk("lit_instr_err", {32'd0, instr}, 64'h00000013);
`else
        chk("lit_instr_err", {32'd0, instr}, 64'h00000000CAFEBABE);
`endif
        RRESP = 2'b00;

        // Reset while waiting in the data phase.
        RVALID = 0;
        step(); step(); step();
        chk("lit_in_data", {63'd0, RREADY}, 64'd1);
        rstn = 1;
        step();
        chk("lit_mrst_arv", {63'd0, ARVALID}, 64'd0); chk("lit_mrst_rr", {63'd0, RREADY}, 64'd0);
        chk("lit_mrst_instr", {32'd0, instr}, 64'd0);
        rstn = 0; RVALID = 1;
        step(); chk("lit_post_rst_arv", {63'd0, ARVALID}, 64'd1);

        // Randomized slave, pc and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            ARREADY = 1'($urandom_range(0, 1));
            RVALID  = 1'($urandom_range(0, 1));
            RDATA   = {$urandom, $urandom};
            RRESP   = 2'($urandom_range(0, 3));
            RID     = 4'($urandom);
            RLAST   = 1'($urandom);
            pc      = {$urandom, $urandom};
            rstn    = ($urandom_range(0, 199) == 0);
            step();
        end
        rstn = 0;
        chk("pulse_count", 64'(d_pulses), 64'(m_pulses));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
